// File: rtl/writeback_unit.sv
// Writeback stage: takes finished results from the LSU or the ALU,
// writes the register file one cycle after accepting them, counts
// retired instructions, and turns taken branches into a PC redirect
// followed by a fixed-length pipeline flush.
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_result_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      alu_rd,
  input  logic            alu_target_valid,
  input  logic [XLEN-1:0] alu_target,
  output logic            alu_ok,
  input  logic            lsu_valid,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [4:0]      lsu_rd,
  output logic            lsu_ok,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_o,
  output logic [63:0]     instret
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  // The redirect cycle itself is the first flush cycle, so the counter
  // starts one short of the total.
  localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            acc_lsu, acc_alu, take_branch;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic [63:0]     instret_q;

  assign take_branch = acc_alu & alu_target_valid;

  // State and flush counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter FLUSH on a taken branch, leave after the counter hits 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (take_branch) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_CNT;
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs / accept decode: LSU wins, idle cycles and flush cycles drain both
  always_comb begin
    acc_lsu = 1'b0;
    acc_alu = 1'b0;
    alu_ok  = 1'b1;
    lsu_ok  = 1'b1;
    flush_o = 1'b0;
    if (state_q == FLUSH) begin
      flush_o = 1'b1;
    end else if (lsu_valid) begin
      acc_lsu = 1'b1;
      alu_ok  = 1'b0;
    end else if (alu_result_valid || alu_target_valid) begin
      acc_alu = 1'b1;
      lsu_ok  = 1'b0;
    end
  end

  // Registered writeback, redirect pulse and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      instret_q        <= '0;
    end else begin
      rf_we_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      if (acc_lsu) begin
        rf_we_q    <= (lsu_rd != 5'd0);
        rf_waddr_q <= lsu_rd;
        rf_wdata_q <= lsu_data;
      end else if (acc_alu) begin
        rf_we_q    <= alu_result_valid && (alu_rd != 5'd0);
        rf_waddr_q <= alu_rd;
        rf_wdata_q <= alu_result;
      end
      if (take_branch) begin
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= alu_target;
      end
      if (acc_lsu || acc_alu) instret_q <= instret_q + 64'd1;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model.
module tb_writeback_unit;
  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_result_valid, alu_target_valid, lsu_valid;
  logic [XLEN-1:0] alu_result, alu_target, lsu_data;
  logic [4:0]      alu_rd, lsu_rd;
  logic            alu_ok, lsu_ok, rf_we, redirect_valid, flush_o;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata, redirect_pc;
  logic [63:0]     instret;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result), .alu_rd(alu_rd),
    .alu_target_valid(alu_target_valid), .alu_target(alu_target), .alu_ok(alu_ok),
    .lsu_valid(lsu_valid), .lsu_data(lsu_data), .lsu_rd(lsu_rd), .lsu_ok(lsu_ok),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_o(flush_o), .instret(instret)
  );

  int nvec = 0;
  int nerr = 0;

  // model: remaining flush cycles plus what should appear after the next edge
  int              m_flush;
  logic            m_we, m_redir;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data, m_pc;
  longint unsigned m_ret;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flush = 0; m_we = 1'b0; m_redir = 1'b0;
    m_addr = '0; m_data = '0; m_pc = '0; m_ret = 0;
  endtask

  // One clock: drive at negedge, check handshakes, advance model, check registered outputs
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                      input logic arv, input logic atv, input logic [4:0] ard,
                      input logic [XLEN-1:0] ares, input logic [XLEN-1:0] atgt);
    logic e_aok, e_lok;
    @(negedge clk);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_result_valid = arv; alu_target_valid = atv; alu_rd = ard;
    alu_result = ares; alu_target = atgt;
    #1;
    if (m_flush > 0)      begin e_aok = 1'b1; e_lok = 1'b1; end
    else if (lv)          begin e_aok = 1'b0; e_lok = 1'b1; end
    else if (arv || atv)  begin e_aok = 1'b1; e_lok = 1'b0; end
    else                  begin e_aok = 1'b1; e_lok = 1'b1; end
    chk("alu_ok", 64'(alu_ok), 64'(e_aok));
    chk("lsu_ok", 64'(lsu_ok), 64'(e_lok));
    chk("flush_o", 64'(flush_o), 64'(m_flush > 0));
    m_we = 1'b0; m_redir = 1'b0;
    if (m_flush > 0) begin
      m_flush--;
    end else if (lv) begin
      m_we = (lrd != 0); m_addr = lrd; m_data = ld; m_ret++;
    end else if (arv || atv) begin
      m_we = arv && (ard != 0); m_addr = ard; m_data = ares; m_ret++;
      if (atv) begin m_redir = 1'b1; m_pc = atgt; m_flush = FC; end
    end
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
    end
    chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
    if (m_redir) chk("redirect_pc", 64'(redirect_pc), 64'(m_pc));
    chk("instret", instret, m_ret);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, '0, 1'b0, 1'b0, 5'd0, '0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    alu_result_valid = 1'b0; alu_target_valid = 1'b0; alu_rd = '0;
    alu_result = '0; alu_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // simple ALU write
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd5, 32'h0000_1234, '0);
    chk("first_wdata", 64'(rf_wdata), 64'h1234);
    chk("first_instret", instret, 64'd1);
    // LSU priority over ALU, then ALU drains
    step(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 1'b0, 5'd4, 32'hBBBB_0004, '0);
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd4, 32'hBBBB_0004, '0);
    // rd = 0: no write, still retires
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, '0);
    // branch-only then two younger ALU entries discarded during flush
    step(1'b0, 5'd0, '0, 1'b0, 1'b1, 5'd0, '0, 32'h8000_0040);
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd9, 32'h1111_1111, '0);
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd10, 32'h2222_2222, '0);
    idle();
    // JALR: write x1 and redirect together
    step(1'b0, 5'd0, '0, 1'b1, 1'b1, 5'd1, 32'h0000_0104, 32'h0000_0200);
    idle();
    // now in the second flush cycle: async reset clears flush immediately
    @(negedge clk);
    chk("pre_rst_flush", 64'(flush_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_flush", 64'(flush_o), 64'd0);
    chk("async_redirect", 64'(redirect_valid), 64'd0);
    chk("async_instret", instret, 64'd0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd7, 32'h0000_0777, '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 4, 5'($urandom_range(0, 31)), $urandom,
           ($urandom % 2) == 1, ($urandom % 8) == 0, 5'($urandom_range(0, 31)),
           $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
